// File: rtl/sram_1r1w_port_arbiter.sv
// sram_1r1w_port_arbiter
// Fronts a single-port (1RW) SRAM macro with independent read and write request
// channels. Reads normally win the macro; one write can be parked in a buffer and
// is forced through after MAX_DEFER consecutive losses. Reads that hit the parked
// write get its enabled bytes forwarded, so 1R1W ordering is preserved.
//
// Write buffer states:
//   state     | meaning
//   BUF_EMPTY | no write parked; a write with no competing read goes straight to the macro
//   BUF_FULL  | one write parked in buf_addr/buf_data/buf_mask, waiting for a macro slot

module sram_1r1w_port_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MASK_W    = 4,
    parameter int MAX_DEFER = 4
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [MASK_W-1:0] wr_mask,

    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,

    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,

    output logic              sram_ce,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int                 DEFER_W     = $clog2(MAX_DEFER + 1);
    localparam logic [DEFER_W-1:0] DEFER_LIMIT = DEFER_W'(MAX_DEFER);

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    buf_state_e          buf_state;
    buf_state_e          buf_state_nxt;
    logic [ADDR_W-1:0]   buf_addr;
    logic [DATA_W-1:0]   buf_data;
    logic [MASK_W-1:0]   buf_mask;
    logic [DEFER_W-1:0]  defer_cnt;

    logic                rsp_pend;
    logic [MASK_W-1:0]   fwd_mask;
    logic [DATA_W-1:0]   fwd_data;

    logic                buf_full;
    logic                defer_sat;
    logic                op_buf_wr;
    logic                op_rd;
    logic                op_direct_wr;
    logic                rd_fire;
    logic                wr_fire;
    logic                buf_load;
    logic                fwd_hit;
    logic [MASK_W-1:0]   op_mask;

    // Pick this cycle's macro operation and derive the channel handshakes.
    // Outputs are held quiet while reset_n is low so nothing reaches the macro.
    always_comb begin
        buf_full     = (buf_state == BUF_FULL);
        defer_sat    = buf_full && (defer_cnt == DEFER_LIMIT);
        op_buf_wr    = 1'b0;
        op_rd        = 1'b0;
        op_direct_wr = 1'b0;
        if (reset_n) begin
            if (defer_sat) begin
                op_buf_wr = 1'b1;
            end else if (rd_valid) begin
                op_rd = 1'b1;
            end else if (buf_full) begin
                op_buf_wr = 1'b1;
            end else if (wr_valid) begin
                op_direct_wr = 1'b1;
            end
        end
        rd_ready = op_rd;
        wr_ready = reset_n && (!buf_full || op_buf_wr);
        rd_fire  = rd_valid && op_rd;
        wr_fire  = wr_valid && wr_ready;
        // Any accepted write that did not go straight to the macro is parked,
        // including one that arrives alongside a read (it is ordered after it).
        buf_load = wr_fire && !op_direct_wr;
        fwd_hit  = rd_fire && buf_full && (buf_addr == rd_addr);
    end

    // Write buffer next state: a newly parked write keeps it full even when the
    // previous occupant drains in the same cycle.
    always_comb begin
        buf_state_nxt = buf_state;
        if (buf_load) begin
            buf_state_nxt = BUF_FULL;
        end else if (op_buf_wr) begin
            buf_state_nxt = BUF_EMPTY;
        end
    end

    // Write buffer state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buf_state <= BUF_EMPTY;
        end else begin
            buf_state <= buf_state_nxt;
        end
    end

    // Capture the parked write's payload.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buf_addr <= '0;
            buf_data <= '0;
            buf_mask <= '0;
        end else if (buf_load) begin
            buf_addr <= wr_addr;
            buf_data <= wr_data;
            buf_mask <= wr_mask;
        end
    end

    // Count consecutive cycles the parked write loses the macro to a read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            defer_cnt <= '0;
        end else if (op_buf_wr) begin
            defer_cnt <= '0;
        end else if (buf_full && rd_fire && (defer_cnt != DEFER_LIMIT)) begin
            defer_cnt <= defer_cnt + 1'b1;
        end
    end

    // Drive the macro pins from the selected operation; the byte mask is
    // expanded to one enable per data bit.
    always_comb begin
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        sram_wmask = '0;
        op_mask    = '0;
        if (op_buf_wr) begin
            sram_ce    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = buf_addr;
            sram_wdata = buf_data;
            op_mask    = buf_mask;
        end else if (op_rd) begin
            sram_ce    = 1'b1;
            sram_addr  = rd_addr;
        end else if (op_direct_wr) begin
            sram_ce    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = wr_addr;
            sram_wdata = wr_data;
            op_mask    = wr_mask;
        end
        for (int i = 0; i < MASK_W; i++) begin
            sram_wmask[8*i +: 8] = {8{op_mask[i]}};
        end
    end

    // Track the read in flight and snapshot any parked bytes it must see.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_pend <= 1'b0;
            fwd_mask <= '0;
            fwd_data <= '0;
        end else begin
            rsp_pend <= rd_fire;
            if (rd_fire) begin
                fwd_mask <= fwd_hit ? buf_mask : '0;
                fwd_data <= buf_data;
            end
        end
    end

    // Merge forwarded bytes over the macro read data; zero when no response.
    always_comb begin
        rsp_data = '0;
        if (rsp_pend) begin
            for (int i = 0; i < MASK_W; i++) begin
                rsp_data[8*i +: 8] = fwd_mask[i] ? fwd_data[8*i +: 8] : sram_rdata[8*i +: 8];
            end
        end
    end

    assign rsp_valid = rsp_pend;

endmodule

// File: tb/tb_sram_1r1w_port_arbiter.sv
// Bench for sram_1r1w_port_arbiter: a behavioural 1RW macro, a directed vector
// table, hand sequences for write starvation and reset during a read, and a random
// phase scored against an ideal 1R1W memory (reads see every earlier-accepted write).

module tb_sram_1r1w_port_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_mask;
    logic        rd_valid;
    logic        rd_ready;
    logic [9:0]  rd_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        sram_ce;
    logic        sram_we;
    logic [9:0]  sram_addr;
    logic [31:0] sram_wmask;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = 32'h0;

    int errors = 0;
    int checks = 0;

    bit [31:0] macro_mem [1024];
    bit [31:0] gold      [1024];
    bit        pend      = 1'b0;
    bit [31:0] pend_data = 32'h0;

    sram_1r1w_port_arbiter dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_mask    (wr_mask),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_addr    (rd_addr),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .sram_ce    (sram_ce),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wmask (sram_wmask),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clock = ~clock;

    // Behavioural single-port macro: bit-masked write, registered read data.
    always @(posedge clock) begin
        if (sram_ce) begin
            if (sram_we) begin
                macro_mem[sram_addr] <= (macro_mem[sram_addr] & ~sram_wmask) | (sram_wdata & sram_wmask);
            end else begin
                sram_rdata <= macro_mem[sram_addr];
            end
        end
    end

    typedef struct {
        logic        wv;
        logic [9:0]  wa;
        logic [31:0] wd;
        logic [3:0]  wm;
        logic        rv;
        logic [9:0]  ra;
        logic        e_wr_rdy;
        logic        e_rd_rdy;
        logic        e_ce;
        logic        e_we;
        logic [9:0]  e_addr;
        logic [31:0] e_wmask;
        logic        e_rsp_v;
        logic [31:0] e_rsp_d;
    } vec_t;

    localparam int NVEC = 25;
    vec_t tbl [NVEC];

    function automatic vec_t mkv(input logic wv, input logic [9:0] wa, input logic [31:0] wd,
                                 input logic [3:0] wm, input logic rv, input logic [9:0] ra,
                                 input logic ewr, input logic erd, input logic ece, input logic ewe,
                                 input logic [9:0] eaddr, input logic [31:0] ewm,
                                 input logic erv, input logic [31:0] erdat);
        vec_t v;
        v.wv = wv; v.wa = wa; v.wd = wd; v.wm = wm; v.rv = rv; v.ra = ra;
        v.e_wr_rdy = ewr; v.e_rd_rdy = erd; v.e_ce = ece; v.e_we = ewe;
        v.e_addr = eaddr; v.e_wmask = ewm; v.e_rsp_v = erv; v.e_rsp_d = erdat;
        return v;
    endfunction

    function automatic logic [31:0] expand(input logic [3:0] m);
        logic [31:0] r;
        r = 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r = r | (32'hFF << (8 * b));
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wv, input logic [9:0] wa, input logic [31:0] wd,
                         input logic [3:0] wm, input logic rv, input logic [9:0] ra);
        @(posedge clock);
        #1;
        wr_valid = wv; wr_addr = wa; wr_data = wd; wr_mask = wm;
        rd_valid = rv; rd_addr = ra;
    endtask

    // Ideal-memory scoreboard, called once per cycle at the falling edge.
    task automatic sb_tick();
        logic [31:0] m;
        bit          bytes_ok;
        if (!reset_n) begin
            pend = 1'b0;
            return;
        end
        if (pend) chk("rsp", 64'({rsp_valid, rsp_data}), 64'({1'b1, pend_data}));
        else      chk("rsp_idle", 64'(rsp_valid), 64'(0));
        if (sram_ce && sram_we) begin
            bytes_ok = 1'b1;
            for (int b = 0; b < 4; b++) begin
                if (sram_wmask[8*b +: 8] != 8'h00 && sram_wmask[8*b +: 8] != 8'hFF) bytes_ok = 1'b0;
            end
            chk("wmask_bytes", 64'(bytes_ok), 64'(1));
        end
        pend = rd_valid && rd_ready;
        if (pend) pend_data = gold[rd_addr];
        if (wr_valid && wr_ready) begin
            m = expand(wr_mask);
            gold[wr_addr] = (gold[wr_addr] & ~m) | (wr_data & m);
        end
    endtask

    task automatic starve_run(input logic [9:0] wa, input logic [31:0] wd);
        int lost;
        bit dropped;
        drive(1'b1, wa, wd, 4'hF, 1'b1, 10'h050);
        @(negedge clock);
        chk("starve_accept", 64'({wr_ready, rd_ready, sram_we}), 64'(3'b110));
        sb_tick();
        lost = 0;
        dropped = 1'b0;
        for (int k = 0; k < 12 && !dropped; k++) begin
            drive(1'b0, 10'h0, 32'h0, 4'h0, 1'b1, 10'h050);
            @(negedge clock);
            if (!rd_ready) begin
                dropped = 1'b1;
                chk("starve_write", 64'({sram_ce, sram_we, sram_addr, sram_wdata}),
                    64'({1'b1, 1'b1, wa, wd}));
            end else begin
                lost++;
            end
            sb_tick();
        end
        chk("starve_dropped", 64'(dropped), 64'(1));
        chk("starve_lost", 64'(lost), 64'(4));
        drive(1'b0, 10'h0, 32'h0, 4'h0, 1'b1, 10'h050);
        @(negedge clock);
        chk("starve_resume", 64'({rd_ready, sram_we}), 64'(2'b10));
        sb_tick();
    endtask

    function automatic logic [9:0] rnd_addr();
        int p;
        p = $urandom_range(0, 8);
        return (p == 8) ? 10'h3FF : 10'(10'h100 + p);
    endfunction

    initial begin
        reset_n  = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
        rd_valid = 1'b0; rd_addr = '0;

        tbl[0]  = mkv(1, 10'h005, 32'hDEADBEEF, 4'hF, 0, 10'h000,  1,1'b0,1,1, 10'h005, 32'hFFFFFFFF, 0, 32'h0);
        tbl[1]  = mkv(0, 10'h000, 32'h0,        4'h0, 1, 10'h005,  1,1,1,0,    10'h005, 32'h0,        0, 32'h0);
        tbl[2]  = mkv(0, 10'h000, 32'h0,        4'h0, 0, 10'h000,  1,0,0,0,    10'h000, 32'h0,        1, 32'hDEADBEEF);
        tbl[3]  = mkv(1, 10'h010, 32'h11223344, 4'hF, 0, 10'h000,  1,0,1,1,    10'h010, 32'hFFFFFFFF, 0, 32'h0);
        tbl[4]  = mkv(1, 10'h010, 32'hAABBCCDD, 4'h3, 1, 10'h020,  1,1,1,0,    10'h020, 32'h0,        0, 32'h0);
        tbl[5]  = mkv(0, 10'h000, 32'h0,        4'h0, 1, 10'h010,  0,1,1,0,    10'h010, 32'h0,        1, 32'h0);
        tbl[6]  = mkv(0, 10'h000, 32'h0,        4'h0, 0, 10'h000,  1,0,1,1,    10'h010, 32'h0000FFFF, 1, 32'h1122CCDD);
        tbl[7]  = mkv(0, 10'h000, 32'h0,        4'h0, 1, 10'h010,  1,1,1,0,    10'h010, 32'h0,        0, 32'h0);
        tbl[8]  = mkv(0, 10'h000, 32'h0,        4'h0, 0, 10'h000,  1,0,0,0,    10'h000, 32'h0,        1, 32'h1122CCDD);
        tbl[9]  = mkv(1, 10'h020, 32'h12345678, 4'hF, 1, 10'h020,  1,1,1,0,    10'h020, 32'h0,        0, 32'h0);
        tbl[10] = mkv(0, 10'h000, 32'h0,        4'h0, 0, 10'h000,  1,0,1,1,    10'h020, 32'hFFFFFFFF, 1, 32'h0);
        tbl[11] = mkv(0, 10'h000, 32'h0,        4'h0, 1, 10'h020,  1,1,1,0,    10'h020, 32'h0,        0, 32'h0);
        tbl[12] = mkv(0, 10'h000, 32'h0,        4'h0, 0, 10'h000,  1,0,0,0,    10'h000, 32'h0,        1, 32'h12345678);
        tbl[13] = mkv(1, 10'h3FF, 32'h11223344, 4'hF, 0, 10'h000,  1,0,1,1,    10'h3FF, 32'hFFFFFFFF, 0, 32'h0);
        tbl[14] = mkv(1, 10'h3FF, 32'hFF000000, 4'h8, 0, 10'h000,  1,0,1,1,    10'h3FF, 32'hFF000000, 0, 32'h0);
        tbl[15] = mkv(0, 10'h000, 32'h0,        4'h0, 1, 10'h3FF,  1,1,1,0,    10'h3FF, 32'h0,        0, 32'h0);
        tbl[16] = mkv(0, 10'h000, 32'h0,        4'h0, 0, 10'h000,  1,0,0,0,    10'h000, 32'h0,        1, 32'hFF223344);
        tbl[17] = mkv(1, 10'h005, 32'h00000000, 4'h0, 0, 10'h000,  1,0,1,1,    10'h005, 32'h00000000, 0, 32'h0);
        tbl[18] = mkv(0, 10'h000, 32'h0,        4'h0, 1, 10'h005,  1,1,1,0,    10'h005, 32'h0,        0, 32'h0);
        tbl[19] = mkv(0, 10'h000, 32'h0,        4'h0, 0, 10'h000,  1,0,0,0,    10'h000, 32'h0,        1, 32'hDEADBEEF);
        tbl[20] = mkv(1, 10'h030, 32'h00000033, 4'hF, 1, 10'h030,  1,1,1,0,    10'h030, 32'h0,        0, 32'h0);
        tbl[21] = mkv(1, 10'h040, 32'h00000055, 4'hF, 0, 10'h000,  1,0,1,1,    10'h030, 32'hFFFFFFFF, 1, 32'h0);
        tbl[22] = mkv(0, 10'h000, 32'h0,        4'h0, 0, 10'h000,  1,0,1,1,    10'h040, 32'hFFFFFFFF, 0, 32'h0);
        tbl[23] = mkv(0, 10'h000, 32'h0,        4'h0, 1, 10'h040,  1,1,1,0,    10'h040, 32'h0,        0, 32'h0);
        tbl[24] = mkv(0, 10'h000, 32'h0,        4'h0, 0, 10'h000,  1,0,0,0,    10'h000, 32'h0,        1, 32'h00000055);

        // Reset state.
        repeat (2) @(negedge clock);
        chk("reset_outputs", 64'({rsp_valid, sram_ce, sram_we, rsp_data}), 64'(0));
        reset_n = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("post_reset", 64'({wr_ready, rd_ready, sram_ce, rsp_valid}), 64'(4'b1000));

        // Directed vector table.
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].wm, tbl[i].rv, tbl[i].ra);
            @(negedge clock);
            chk($sformatf("vec%0d_ctl", i),
                64'({wr_ready, rd_ready, sram_ce, sram_we, rsp_valid, rsp_data}),
                64'({tbl[i].e_wr_rdy, tbl[i].e_rd_rdy, tbl[i].e_ce, tbl[i].e_we,
                     tbl[i].e_rsp_v, tbl[i].e_rsp_d}));
            if (tbl[i].e_ce) chk($sformatf("vec%0d_addr", i), 64'(sram_addr), 64'(tbl[i].e_addr));
            if (tbl[i].e_we) chk($sformatf("vec%0d_wmask", i), 64'(sram_wmask), 64'(tbl[i].e_wmask));
            sb_tick();
        end

        // Write starvation bound, twice in a row to show the defer count restarts.
        starve_run(10'h060, 32'h00000077);
        starve_run(10'h061, 32'h00000088);

        // Random traffic against the ideal 1R1W memory.
        for (int c = 0; c < 800; c++) begin
            drive(1'($urandom_range(0, 1)), rnd_addr(), $urandom(), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 99) < 60), rnd_addr());
            @(negedge clock);
            sb_tick();
        end
        drive(1'b0, 10'h0, 32'h0, 4'h0, 1'b0, 10'h0);
        @(negedge clock);
        sb_tick();

        // Reset while a read is in flight and a write is parked.
        drive(1'b1, 10'h070, 32'h12121212, 4'hF, 1'b1, 10'h005);
        @(negedge clock);
        sb_tick();
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("reset_mid_read", 64'({rsp_valid, sram_ce, sram_we, rsp_data}), 64'(0));
        @(negedge clock);
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        pend = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("reset_release", 64'({wr_ready, rd_ready, sram_ce, rsp_valid}), 64'(4'b1000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
